// File: rtl/spawn_point_gen.sv
// ---------------------------------------------------------------------------
// spawn_point_gen
//
// Purpose:
//   Consumer of the LFSR random source. On a spawn request it pulses the
//   LFSR enable, samples the advanced word one cycle later and turns the
//   draws into a bounded duck spawn descriptor: X position, Y position,
//   direction, and a tick-counted spawn delay. The finished descriptor is
//   offered to the game-control FSM with a valid/ready handshake.
//
//   Optional feature macro: SPAWN_REJECT_EN
//     defined   - X out of range is redrawn, up to MAX_TRIES draws, after
//                 which the wrapped value c - X_RANGE is used.
//     undefined - X is always taken from the first draw, out-of-range
//                 values wrapped to c - X_RANGE. MAX_TRIES is unused.
//
// Parameters:
//   RND_W     width of the random word (must be 16)
//   X_RANGE   X drawn from 0..X_RANGE-1 (512..1024)
//   Y_MIN     offset added to the 8-bit Y draw
//   DELAY_MIN minimum spawn delay in ticks
//   MAX_TRIES X draws before the wrapped fallback is used (1..15)
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-high reset
//   rnd_in       current LFSR value
//   rnd_en       one-cycle enable pulse to the LFSR per draw
//   tick         timebase pulse that decrements the spawn delay
//   spawn_req    request for a new spawn, sampled only while idle
//   spawn_valid  descriptor available
//   spawn_ready  consumer accepts the descriptor
//   spawn_x      X position, always < X_RANGE
//   spawn_y      Y position, Y_MIN..Y_MIN+255
//   spawn_dir    0 = left-to-right, 1 = right-to-left
//   busy         high whenever not idle
// ---------------------------------------------------------------------------
// state   | meaning
// --------+------------------------------------------------------------------
// IDLE    | waiting for spawn_req
// DRAW_X  | rnd_en pulse for the X draw
// CHK_X   | sample X candidate, accept / wrap / redraw
// DRAW_Y  | rnd_en pulse for the Y/dir/delay draw
// CHK_Y   | load Y, direction and delay counter
// DELAY   | count ticks down to zero
// VALID   | descriptor offered, wait for spawn_ready
// ---------------------------------------------------------------------------
module spawn_point_gen #(
  parameter int RND_W     = 16,
  parameter int X_RANGE   = 960,
  parameter int Y_MIN     = 64,
  parameter int DELAY_MIN = 16,
  parameter int MAX_TRIES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [RND_W-1:0] rnd_in,
  output logic             rnd_en,
  input  logic             tick,
  input  logic             spawn_req,
  output logic             spawn_valid,
  input  logic             spawn_ready,
  output logic [9:0]       spawn_x,
  output logic [9:0]       spawn_y,
  output logic             spawn_dir,
  output logic             busy
);

  // Elaboration-time parameter legality checks.
  if (RND_W != 16) begin : g_bad_rnd_w
    $error("spawn_point_gen: RND_W must be 16");
  end
  if (X_RANGE < 512 || X_RANGE > 1024) begin : g_bad_x_range
    $error("spawn_point_gen: X_RANGE must be 512..1024");
  end
  if (MAX_TRIES < 1 || MAX_TRIES > 15) begin : g_bad_max_tries
    $error("spawn_point_gen: MAX_TRIES must be 1..15");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DRAW_X = 3'd1,
    S_CHK_X  = 3'd2,
    S_DRAW_Y = 3'd3,
    S_CHK_Y  = 3'd4,
    S_DELAY  = 3'd5,
    S_VALID  = 3'd6
  } state_t;

  localparam logic [10:0] XR_11   = 11'(X_RANGE);
  localparam logic [9:0]  YMIN_10 = 10'(Y_MIN);
  localparam logic [7:0]  DMIN_8  = 8'(DELAY_MIN);

  state_t     state_q, state_d;
  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic       dir_q, dir_d;
  logic [7:0] cnt_q, cnt_d;
  logic       rnd_en_q;
  logic       valid_q;
  logic       busy_q;

  // X candidate and its wrapped form. The wrap is only used when the
  // candidate is >= X_RANGE, so the low 10 bits of the difference are
  // always a legal X (X_RANGE >= 512 keeps it below X_RANGE).
  logic [9:0] cand;
  logic       cand_ok;
  logic [9:0] cand_wrap;

  assign cand      = rnd_in[9:0];
  assign cand_ok   = ({1'b0, cand} < XR_11);
  assign cand_wrap = cand - XR_11[9:0];

`ifdef SPAWN_REJECT_EN
  localparam logic [3:0] MT_4 = 4'(MAX_TRIES);
  logic [3:0] tries_q, tries_d;
`endif

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
`ifdef SPAWN_REJECT_EN
    tries_d = tries_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (spawn_req) begin
`ifdef SPAWN_REJECT_EN
          tries_d = '0;
`endif
          state_d = S_DRAW_X;
        end
      end
      S_DRAW_X: state_d = S_CHK_X;
      S_CHK_X: begin
`ifdef SPAWN_REJECT_EN
        tries_d = tries_q + 4'd1;
        if (cand_ok) begin
          x_d     = cand;
          state_d = S_DRAW_Y;
        end else if (tries_d == MT_4) begin
          x_d     = cand_wrap;
          state_d = S_DRAW_Y;
        end else begin
          state_d = S_DRAW_X;
        end
`else
        x_d     = cand_ok ? cand : cand_wrap;
        state_d = S_DRAW_Y;
`endif
      end
      S_DRAW_Y: state_d = S_CHK_Y;
      S_CHK_Y: begin
        y_d     = YMIN_10 + {2'b00, rnd_in[7:0]};
        dir_d   = rnd_in[15];
        cnt_d   = DMIN_8 + {1'b0, rnd_in[14:8]};
        state_d = S_DELAY;
      end
      S_DELAY: begin
        // Only ticks seen while already in DELAY count; a zero counter
        // leaves on the next edge regardless of tick.
        if (cnt_q == 8'd0) begin
          state_d = S_VALID;
        end else if (tick) begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_VALID: begin
        if (spawn_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the
  // state register and never see a combinational path from the inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      x_q      <= '0;
      y_q      <= '0;
      dir_q    <= 1'b0;
      cnt_q    <= '0;
      rnd_en_q <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
`ifdef SPAWN_REJECT_EN
      tries_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      dir_q    <= dir_d;
      cnt_q    <= cnt_d;
      rnd_en_q <= (state_d == S_DRAW_X) || (state_d == S_DRAW_Y);
      valid_q  <= (state_d == S_VALID);
      busy_q   <= (state_d != S_IDLE);
`ifdef SPAWN_REJECT_EN
      tries_q  <= tries_d;
`endif
    end
  end

  assign rnd_en      = rnd_en_q;
  assign spawn_valid = valid_q;
  assign busy        = busy_q;
  assign spawn_x     = x_q;
  assign spawn_y     = y_q;
  assign spawn_dir   = dir_q;

endmodule

// File: tb/tb_spawn_point_gen.sv
// ---------------------------------------------------------------------------
// tb_spawn_point_gen
//
// Self-checking bench for spawn_point_gen. Plays the LFSR: each rnd_en
// pulse seen on the falling edge advances rnd_in to the next word of a
// prepared sequence. Expected descriptors and the spawn_valid cycle are
// computed from that sequence and the tick pattern by a small model.
// Works with SPAWN_REJECT_EN defined or undefined.
// ---------------------------------------------------------------------------
module tb_spawn_point_gen;

  localparam int X_RANGE   = 960;
  localparam int Y_MIN     = 64;
  localparam int DELAY_MIN = 16;
  localparam int MAX_TRIES = 4;
`ifdef SPAWN_REJECT_EN
  localparam bit REJ = 1'b1;
`else
  localparam bit REJ = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [15:0] rnd_in;
  logic        rnd_en;
  logic        tick;
  logic        spawn_req;
  logic        spawn_valid;
  logic        spawn_ready;
  logic [9:0]  spawn_x;
  logic [9:0]  spawn_y;
  logic        spawn_dir;
  logic        busy;

  int errors = 0;
  int checks = 0;

  logic [15:0] seq  [8];
  bit          tpat [2048];
  int          wi;
  int          pulses;

  spawn_point_gen #(
    .RND_W    (16),
    .X_RANGE  (X_RANGE),
    .Y_MIN    (Y_MIN),
    .DELAY_MIN(DELAY_MIN),
    .MAX_TRIES(MAX_TRIES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rnd_in     (rnd_in),
    .rnd_en     (rnd_en),
    .tick       (tick),
    .spawn_req  (spawn_req),
    .spawn_valid(spawn_valid),
    .spawn_ready(spawn_ready),
    .spawn_x    (spawn_x),
    .spawn_y    (spawn_y),
    .spawn_dir  (spawn_dir),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One cycle: wait for the falling edge, then act as the LFSR.
  task automatic step();
    @(negedge clk);
    if (rnd_en) begin
      pulses++;
      rnd_in = (wi < 8) ? seq[wi] : 16'($urandom);
      wi++;
    end
  endtask

  // Descriptor the spawn rules produce from the word sequence.
  function automatic void model(output int nx, output int ex, output int ey,
                                output int edir, output int ed);
    int c;
    int tries;
    tries = 0;
    nx    = 0;
    ex    = -1;
    while (ex < 0) begin
      c = int'(seq[nx][9:0]);
      nx++;
      tries++;
      if (c < X_RANGE) ex = c;
      else if (!REJ || tries == MAX_TRIES) ex = c - X_RANGE;
    end
    ey   = Y_MIN + int'(seq[nx][7:0]);
    edir = int'(seq[nx][15]);
    ed   = DELAY_MIN + int'(seq[nx][14:8]);
  endfunction

  function automatic logic [15:0] xword(input int c);
    logic [15:0] w;
    w = 16'($urandom);
    w[9:0] = 10'(c);
    return w;
  endfunction

  task automatic fill_ticks(input int mode);
    for (int i = 0; i < 2048; i++)
      tpat[i] = (mode == 1) ? 1'b1 : ($urandom_range(0, 3) != 0);
  endtask

  // Full spawn transaction. Cycle 0 is the cycle spawn_req is sampled.
  task automatic run_spawn(input bit ready_hi, input int hold, input string tag);
    int nx, ex, ey, edir, ed;
    int c, acc, expv, vcyc, cyc, p0;
    bit stable;
    model(nx, ex, ey, edir, ed);
    // DELAY is entered at cycle 2*nx+3; ticks from then on count down.
    c   = 2 * nx + 3;
    acc = 0;
    while (acc < ed && c < 2000) begin
      acc += int'(tpat[c]);
      c++;
    end
    expv = c + 1;

    wi = 0;
    pulses = 0;
    spawn_ready = ready_hi;
    step();
    spawn_req = 1'b1;
    tick = tpat[0];
    cyc = 0;
    vcyc = -1;
    while (vcyc < 0 && cyc < 1800) begin
      step();
      cyc++;
      spawn_req = 1'b0;
      tick = tpat[cyc];
      if (spawn_valid) vcyc = cyc;
    end
    tick = 1'b0;
    chk({tag, " valid_cycle"}, vcyc, expv);
    chk({tag, " spawn_x"}, 32'(spawn_x), ex);
    chk({tag, " spawn_y"}, 32'(spawn_y), ey);
    chk({tag, " spawn_dir"}, 32'(spawn_dir), edir);
    chk({tag, " rnd_en_pulses"}, pulses, nx + 1);
    if (vcyc < 0) begin
      rst = 1'b1;
      step();
      rst = 1'b0;
      spawn_ready = 1'b0;
      return;
    end

    if (ready_hi) begin
      step();
      chk({tag, " valid_one_cycle"}, 32'(spawn_valid), 0);
      chk({tag, " busy_after_accept"}, 32'(busy), 0);
      spawn_ready = 1'b0;
    end else begin
      stable = 1'b1;
      p0 = pulses;
      for (int i = 1; i <= hold; i++) begin
        step();
        spawn_req = (i == 4);
        if (spawn_valid !== 1'b1 || busy !== 1'b1 || int'(spawn_x) != ex ||
            int'(spawn_y) != ey || int'(spawn_dir) != edir)
          stable = 1'b0;
      end
      chk({tag, " stable_under_backpressure"}, 32'(stable), 1);
      chk({tag, " no_draw_under_backpressure"}, pulses - p0, 0);
      spawn_req = 1'b0;
      spawn_ready = 1'b1;
      step();
      chk({tag, " valid_after_accept"}, 32'(spawn_valid), 0);
      chk({tag, " busy_after_accept"}, 32'(busy), 0);
      spawn_ready = 1'b0;
      step();
      chk({tag, " req_not_queued"}, 32'(busy), 0);
    end
  endtask

  initial begin
    int nv;
    rst = 1'b1;
    rnd_in = 16'h0000;
    tick = 1'b0;
    spawn_req = 1'b0;
    spawn_ready = 1'b0;
    wi = 0;
    pulses = 0;
    step();
    step();
    chk("reset busy", 32'(busy), 0);
    chk("reset spawn_valid", 32'(spawn_valid), 0);
    chk("reset rnd_en", 32'(rnd_en), 0);
    chk("reset spawn_x", 32'(spawn_x), 0);
    chk("reset spawn_y", 32'(spawn_y), 0);
    chk("reset spawn_dir", 32'(spawn_dir), 0);
    rst = 1'b0;
    step();

    // Reset in the middle of DELAY with counter 40 (16 + 24).
    seq[0] = 16'h0155;
    seq[1] = 16'h1800;
    for (int i = 2; i < 8; i++) seq[i] = 16'($urandom);
    wi = 0;
    pulses = 0;
    tick = 1'b0;
    step();
    spawn_req = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      spawn_req = 1'b0;
    end
    chk("delay busy", 32'(busy), 1);
    chk("delay spawn_valid", 32'(spawn_valid), 0);
    chk("delay spawn_x", 32'(spawn_x), 341);
    chk("delay pulses", pulses, 2);
    rst = 1'b1;
    #1;
    chk("midrst busy", 32'(busy), 0);
    chk("midrst spawn_valid", 32'(spawn_valid), 0);
    chk("midrst rnd_en", 32'(rnd_en), 0);
    chk("midrst spawn_x", 32'(spawn_x), 0);
    chk("midrst spawn_y", 32'(spawn_y), 0);
    step();
    rst = 1'b0;
    tick = 1'b1;
    nv = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (spawn_valid || busy) nv++;
    end
    tick = 1'b0;
    chk("after_reset stays idle", nv, 0);

    // Directed descriptor: x=341, y=96, dir=0, delay 19, tick every cycle.
    seq[0] = 16'h0155;
    seq[1] = 16'h0320;
    fill_ticks(1);
    run_spawn(1'b1, 0, "directed");

`ifdef SPAWN_REJECT_EN
    seq[0] = xword(1000);
    seq[1] = xword(1000);
    seq[2] = xword(100);
    seq[3] = 16'($urandom);
    fill_ticks(1);
    run_spawn(1'b1, 0, "reject_then_accept");

    for (int i = 0; i < 4; i++) seq[i] = xword(1000);
    seq[4] = 16'($urandom);
    fill_ticks(1);
    run_spawn(1'b1, 0, "reject_fallback");
`else
    seq[0] = xword(1000);
    seq[1] = 16'($urandom);
    fill_ticks(1);
    run_spawn(1'b1, 0, "wrap_first_draw");
`endif

    // Backpressure: ready low for 10 cycles with a stray request.
    for (int i = 0; i < 8; i++) seq[i] = 16'($urandom);
    seq[0] = xword($urandom_range(0, 959));
    fill_ticks(2);
    run_spawn(1'b0, 10, "backpressure");

    // Randomised transactions, roughly half the X draws out of range.
    for (int n = 0; n < 20; n++) begin
      for (int i = 0; i < 8; i++) begin
        if ($urandom_range(0, 1) == 1) seq[i] = xword(960 + $urandom_range(0, 63));
        else seq[i] = xword($urandom_range(0, 959));
      end
      fill_ticks($urandom_range(1, 2));
      run_spawn(1'($urandom_range(0, 1)), $urandom_range(1, 6), $sformatf("rand%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
